// File: rtl/stage_one_pkg.sv
// Shared definitions for the stage-one arbiter slice.
// Widths, watchdog default and sequencer state encodings.
package stage_one_pkg;

    localparam int FLT_DATA_WIDTH = 32;
    localparam int CORDIC_WIDTH   = 22;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int TMR_WIDTH      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_ABORT
    } state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with its own last-grant register.
// Ready is combinational from valid so a grant can complete in one cycle.
module rr_grant2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant,
    output logic ready0,
    output logic ready1,
    output logic fire
);

    logic last_grant;

    // On a tie the requester not served last wins.
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

    assign ready0 = enable & valid0 & ~grant;
    assign ready1 = enable & valid1 & grant;
    assign fire   = ready0 | ready1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (fire) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/stage_one_arbiter.sv
// Two-port arbiter and sequencer in front of the stage-one front end.
// Issues one job at a time, holds the operand, and guards it with a watchdog.
module stage_one_arbiter #(
    parameter int FLT_DATA_WIDTH = stage_one_pkg::FLT_DATA_WIDTH,
    parameter int CORDIC_WIDTH   = stage_one_pkg::CORDIC_WIDTH,
    parameter int TIMEOUT_CYCLES = stage_one_pkg::TIMEOUT_CYCLES,
    parameter int TMR_WIDTH      = stage_one_pkg::TMR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [FLT_DATA_WIDTH-1:0] req0_x,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [FLT_DATA_WIDTH-1:0] req1_x,
    output logic                      req1_ready,
    output logic                      s1_rst,
    output logic                      s1_start,
    output logic                      s1_clk_en,
    output logic [FLT_DATA_WIDTH-1:0] s1_x,
    input  logic                      s1_done,
    input  logic [FLT_DATA_WIDTH-1:0] s1_half,
    input  logic [FLT_DATA_WIDTH-1:0] s1_square,
    input  logic [CORDIC_WIDTH-1:0]   s1_cordic,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_id,
    output logic                      resp_err,
    output logic [FLT_DATA_WIDTH-1:0] resp_half,
    output logic [FLT_DATA_WIDTH-1:0] resp_square,
    output logic [CORDIC_WIDTH-1:0]   resp_cordic,
    output logic                      busy
);

    import stage_one_pkg::*;

    state_t state;
    state_t state_next;

    logic                      grant;
    logic                      handshake;
    logic                      in_idle;
    logic                      wd_expired;
    logic [TMR_WIDTH-1:0]      wd;
    logic [FLT_DATA_WIDTH-1:0] x_reg;

    assign in_idle    = (state == S_IDLE);
    assign wd_expired = (wd == TMR_WIDTH'(TIMEOUT_CYCLES - 1));

    rr_grant2 u_grant (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .enable (in_idle),
        .grant  (grant),
        .ready0 (req0_ready),
        .ready1 (req1_ready),
        .fire   (handshake)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (handshake) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            // A done on the final watchdog cycle still completes normally.
            S_WAIT: begin
                if (s1_done) begin
                    state_next = S_HOLD;
                end else if (wd_expired) begin
                    state_next = S_ABORT;
                end
            end
            S_ABORT: state_next = S_HOLD;
            S_HOLD:  if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign s1_start   = (state == S_ISSUE);
    assign s1_clk_en  = (state == S_ISSUE) | (state == S_WAIT);
    assign s1_rst     = rst | (state == S_ABORT);
    assign s1_x       = x_reg;
    assign resp_valid = (state == S_HOLD);
    assign busy       = ~in_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wd          <= '0;
            x_reg       <= '0;
            resp_id     <= 1'b0;
            resp_err    <= 1'b0;
            resp_half   <= '0;
            resp_square <= '0;
            resp_cordic <= '0;
        end else begin
            state <= state_next;
            if (handshake) begin
                x_reg   <= grant ? req1_x : req0_x;
                resp_id <= grant;
            end
            if (state == S_ISSUE) begin
                wd <= '0;
            end else if (state == S_WAIT) begin
                wd <= wd + 1'b1;
            end
            if (state == S_WAIT && s1_done) begin
                resp_half   <= s1_half;
                resp_square <= s1_square;
                resp_cordic <= s1_cordic;
                resp_err    <= 1'b0;
            end
            if (state == S_ABORT) begin
                resp_half   <= '0;
                resp_square <= '0;
                resp_cordic <= '0;
                resp_err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage_one_arbiter.sv
// Bench for stage_one_arbiter: stage-one model with programmable latency,
// scoreboard of expected responses checked as they are consumed.
module tb_stage_one_arbiter;

    localparam int FW = 32;
    localparam int CW = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [FW-1:0] req0_x = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [FW-1:0] req1_x = '0;
    logic          req1_ready;
    logic          s1_rst, s1_start, s1_clk_en;
    logic [FW-1:0] s1_x;
    logic          s1_done;
    logic [FW-1:0] s1_half, s1_square;
    logic [CW-1:0] s1_cordic;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic          resp_id, resp_err;
    logic [FW-1:0] resp_half, resp_square;
    logic [CW-1:0] resp_cordic;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          id;
        logic          err;
        logic [FW-1:0] half;
        logic [FW-1:0] square;
        logic [CW-1:0] cordic;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    stage_one_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_x      (req0_x),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_x      (req1_x),
        .req1_ready  (req1_ready),
        .s1_rst      (s1_rst),
        .s1_start    (s1_start),
        .s1_clk_en   (s1_clk_en),
        .s1_x        (s1_x),
        .s1_done     (s1_done),
        .s1_half     (s1_half),
        .s1_square   (s1_square),
        .s1_cordic   (s1_cordic),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_err    (resp_err),
        .resp_half   (resp_half),
        .resp_square (resp_square),
        .resp_cordic (resp_cordic),
        .busy        (busy)
    );

    function automatic logic [FW-1:0] m_half(input logic [FW-1:0] x);
        if (x == 32'h40000000) return 32'h3F800000;
        return x - 32'h00800000;
    endfunction

    function automatic logic [FW-1:0] m_square(input logic [FW-1:0] x);
        if (x == 32'h40000000) return 32'h40800000;
        return {x[30:0], 1'b1};
    endfunction

    function automatic logic [CW-1:0] m_cordic(input logic [FW-1:0] x);
        if (x == 32'h40000000) return 22'h0A0000;
        return x[CW-1:0] ^ 22'h2AAAAA;
    endfunction

    // Stage-one model: lat cycles from start sample to done sample; 0 = hang.
    int            lat = 6;
    logic          m_run = 1'b0;
    int            m_cnt = 0;
    logic [FW-1:0] m_x = '0;

    always @(posedge clk) begin
        if (s1_rst) begin
            m_run <= 1'b0;
            m_cnt <= 0;
        end else if (s1_start) begin
            m_run <= 1'b1;
            m_x   <= s1_x;
            m_cnt <= (lat == 0) ? 0 : lat - 1;
        end else if (m_run) begin
            if (s1_done) m_run <= 1'b0;
            else if (m_cnt != 0) m_cnt <= m_cnt - 1;
        end
    end

    assign s1_done   = m_run && (lat != 0) && (m_cnt == 0);
    assign s1_half   = m_half(m_x);
    assign s1_square = m_square(m_x);
    assign s1_cordic = m_cordic(m_x);

    int start_cnt = 0;
    int abort_cnt = 0;
    int wait_cnt  = 0;
    int last_wait = 0;

    always @(negedge clk) begin
        exp_t e;
        if (s1_start) begin
            start_cnt++;
            wait_cnt = 0;
        end else if (s1_clk_en) begin
            wait_cnt++;
        end
        if (s1_rst && !rst) begin
            abort_cnt++;
            last_wait = wait_cnt;
        end
        if (m_run && s1_clk_en && !s1_start && !rst) begin
            checks++;
            if (s1_x !== m_x) begin
                errors++;
                $display("FAIL s1_x_stable: got %h, required %h", s1_x, m_x);
            end
        end
        if (resp_valid && resp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got id %0d err %0d, required none",
                         resp_id, resp_err);
            end else begin
                e = sb.pop_front();
                if ({resp_id, resp_err, resp_half, resp_square, resp_cordic} !==
                    {e.id, e.err, e.half, e.square, e.cordic}) begin
                    errors++;
                    $display("FAIL resp: got id=%0d err=%0d h=%h s=%h c=%h, required id=%0d err=%0d h=%h s=%h c=%h",
                             resp_id, resp_err, resp_half, resp_square, resp_cordic,
                             e.id, e.err, e.half, e.square, e.cordic);
                end
            end
        end
    end

    function automatic exp_t make_exp(input logic id, input logic [FW-1:0] x,
                                      input logic err);
        exp_t e;
        e.id     = id;
        e.err    = err;
        e.half   = err ? '0 : m_half(x);
        e.square = err ? '0 : m_square(x);
        e.cordic = err ? '0 : m_cordic(x);
        return e;
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    // Presents one operand, returns just after the handshake edge.
    task automatic send(input logic id, input logic [FW-1:0] x, input logic err);
        int  n = 0;
        bit  got = 0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_x = x; end
        else    begin req0_valid = 1'b1; req0_x = x; end
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = id ? req1_ready : req0_ready;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake_timeout: got no ready, required ready on port %0d", id);
        end else begin
            sb.push_back(make_exp(id, x, err));
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s1_rst, busy, resp_valid, s1_start, s1_clk_en, req0_ready, req1_ready,
             resp_id, resp_err} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required %b",
                     {s1_rst, busy, resp_valid, s1_start, s1_clk_en, req0_ready,
                      req1_ready, resp_id, resp_err}, 9'b1_0000_0000);
        end
        checks++;
        if ({s1_x, resp_half, resp_square, resp_cordic} !== '0) begin
            errors++;
            $display("FAIL reset_data: got x=%h h=%h s=%h c=%h, required all 0",
                     s1_x, resp_half, resp_square, resp_cordic);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s1_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got s1_rst=%b busy=%b, required 0 0", s1_rst, busy);
        end
    endtask

    task automatic test_single();
        int base;
        lat = 6;
        base = start_cnt;
        send(1'b0, 32'h40000000, 1'b0);
        @(negedge clk);
        checks++;
        if (s1_start !== 1'b1 || s1_x !== 32'h40000000) begin
            errors++;
            $display("FAIL single_issue: got start=%b x=%h, required 1 40000000", s1_start, s1_x);
        end
        drain(50);
        checks++;
        if (start_cnt - base != 1) begin
            errors++;
            $display("FAIL single_start_width: got %0d cycles, required 1", start_cnt - base);
        end
    endtask

    task automatic test_alternate();
        logic [FW-1:0] ops0[4];
        logic [FW-1:0] ops1[4];
        int i0 = 0;
        int i1 = 0;
        int n = 0;
        int cyc = 0;
        ops0 = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h41000000};
        ops1 = '{32'h3E800000, 32'h42C80000, 32'hBF800000, 32'h00800000};
        apply_reset();
        lat = 4;
        req0_valid = 1'b1; req0_x = ops0[0];
        req1_valid = 1'b1; req1_x = ops1[0];
        while ((i0 < 4 || i1 < 4) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (req0_ready || req1_ready) begin
                checks++;
                if (req1_ready !== 1'(n % 2)) begin
                    errors++;
                    $display("FAIL grant_order: got id %0d, required %0d", req1_ready, n % 2);
                end
                if (req0_ready) begin
                    sb.push_back(make_exp(1'b0, ops0[i0], 1'b0));
                    i0++;
                end else begin
                    sb.push_back(make_exp(1'b1, ops1[i1], 1'b0));
                    i1++;
                end
                n++;
            end
            @(posedge clk); #1;
            req0_valid = (i0 < 4);
            if (i0 < 4) req0_x = ops0[i0];
            req1_valid = (i1 < 4);
            if (i1 < 4) req1_x = ops1[i1];
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL alternate_count: got %0d grants, required 8", n);
        end
        drain(100);
    endtask

    task automatic test_timeout();
        int base;
        lat = 0;
        base = abort_cnt;
        send(1'b1, 32'h3F000000, 1'b1);
        drain(200);
        checks++;
        if (abort_cnt - base != 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, required 1", abort_cnt - base);
        end
        checks++;
        if (last_wait != 64) begin
            errors++;
            $display("FAIL timeout_wait_cycles: got %0d, required 64", last_wait);
        end
        lat = 6;
        base = abort_cnt;
        send(1'b0, 32'h41200000, 1'b0);
        drain(100);
        checks++;
        if (abort_cnt != base) begin
            errors++;
            $display("FAIL timeout_recover: got %0d aborts, required 0", abort_cnt - base);
        end
    endtask

    task automatic test_hold();
        logic [FW+FW+CW+1:0] snap;
        int n = 0;
        int base;
        lat = 3;
        resp_ready = 1'b0;
        send(1'b1, 32'h40A00000, 1'b0);
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        snap = {resp_id, resp_err, resp_half, resp_square, resp_cordic};
        base = start_cnt;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_x = 32'h11111111;
        req1_valid = 1'b1; req1_x = 32'h22222222;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({resp_id, resp_err, resp_half, resp_square, resp_cordic} !== snap ||
                resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable: got %h valid=%b, required %h valid=1",
                         {resp_id, resp_err, resp_half, resp_square, resp_cordic},
                         resp_valid, snap);
            end
            checks++;
            if ({req0_ready, req1_ready, s1_start} !== 3'b000) begin
                errors++;
                $display("FAIL hold_blocked: got r0=%b r1=%b start=%b, required 0 0 0",
                         req0_ready, req1_ready, s1_start);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        drain(20);
        checks++;
        if (start_cnt != base) begin
            errors++;
            $display("FAIL hold_no_start: got %0d starts, required 0", start_cnt - base);
        end
    endtask

    task automatic test_boundary();
        int base;
        lat = 64;
        base = abort_cnt;
        send(1'b0, 32'h40490FDB, 1'b0);
        drain(200);
        checks++;
        if (abort_cnt != base) begin
            errors++;
            $display("FAIL boundary_last_cycle: got %0d aborts, required 0", abort_cnt - base);
        end
        lat = 65;
        send(1'b1, 32'h40490FDB, 1'b1);
        drain(200);
        checks++;
        if (abort_cnt - base != 1) begin
            errors++;
            $display("FAIL boundary_past_last: got %0d aborts, required 1", abort_cnt - base);
        end
        lat = 6;
    endtask

    task automatic test_reset_mid();
        lat = 20;
        send(1'b0, 32'h3FC00000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s1_rst, busy, resp_valid, s1_start, s1_clk_en, resp_id, resp_err} !== 7'b100_0000 ||
            {s1_x, resp_half, resp_square, resp_cordic} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got ctrl=%b x=%h h=%h, required 1000000 0 0",
                     {s1_rst, busy, resp_valid, s1_start, s1_clk_en, resp_id, resp_err},
                     s1_x, resp_half);
        end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 6;
        send(1'b1, 32'h40000000, 1'b0);
        drain(100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_timeout();
        test_hold();
        test_boundary();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
